// File: rtl/ieee80211_conv_punct.sv
// 802.11 OFDM K=7 convolutional encoder (133o/171o) with per-frame puncturing to 1/2, 2/3 or 3/4.
// WIDTH input bits are encoded per AXI-Stream beat into a single registered output stage.
module ieee80211_conv_punct #(
   parameter  int WIDTH = 24,
   localparam int CNT_W = $clog2(2*WIDTH+1)
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [WIDTH-1:0]     s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic                 s_axis_tlast,
   input  logic [3:0]           s_axis_tuser,
   output logic [2*WIDTH-1:0]   m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic [3:0]           m_axis_tuser,
   output logic [CNT_W-1:0]     m_axis_tbits
);

   generate
      if (WIDTH % 6 != 0) begin : g_width_chk
         $error("ieee80211_conv_punct: WIDTH must be a multiple of 6");
      end
   endgenerate

   typedef enum logic {S_IDLE = 1'b0, S_FRAME = 1'b1} state_t;

   localparam logic [1:0] R12 = 2'd0;
   localparam logic [1:0] R23 = 2'd1;
   localparam logic [1:0] R34 = 2'd2;

   localparam logic [CNT_W-1:0] BITS12 = CNT_W'(2*WIDTH);
   localparam logic [CNT_W-1:0] BITS23 = CNT_W'(3*WIDTH/2);
   localparam logic [CNT_W-1:0] BITS34 = CNT_W'(4*WIDTH/3);

   function automatic logic [1:0] rate_decode(input logic [3:0] code);
      case (code)
         4'b1101, 4'b0101, 4'b1001:          rate_decode = R12;
         4'b0001:                            rate_decode = R23;
         4'b1111, 4'b0111, 4'b1011, 4'b0011: rate_decode = R34;
         default:                            rate_decode = R12;
      endcase
   endfunction

   state_t               state_q, state_d;
   logic [5:0]           enc_q, enc_d;
   logic [3:0]           code_q, code_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_last_q, out_last_d;
   logic [2*WIDTH-1:0]   out_data_q, out_data_d;
   logic [3:0]           out_user_q, out_user_d;
   logic [CNT_W-1:0]     out_bits_q, out_bits_d;

   logic                 accept;
   logic [3:0]           beat_code;
   logic [1:0]           beat_rate;

   // st[i][0] is d1 (previous bit) ... st[i][5] is d6, before input bit i
   logic [5:0]           st [0:WIDTH];
   logic [WIDTH-1:0]     enc_a, enc_b;
   logic [2*WIDTH-1:0]   pack12, pack23, pack34;

   assign st[0] = enc_q;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_enc
         assign enc_a[gi]  = s_axis_tdata[gi] ^ st[gi][1] ^ st[gi][2] ^ st[gi][4] ^ st[gi][5];
         assign enc_b[gi]  = s_axis_tdata[gi] ^ st[gi][0] ^ st[gi][1] ^ st[gi][2] ^ st[gi][5];
         assign st[gi+1]   = {st[gi][4:0], s_axis_tdata[gi]};
         assign pack12[2*gi]   = enc_a[gi];
         assign pack12[2*gi+1] = enc_b[gi];
      end
      for (genvar gi = 0; gi < WIDTH/2; gi++) begin : g_p23
         assign pack23[3*gi]   = enc_a[2*gi];
         assign pack23[3*gi+1] = enc_b[2*gi];
         assign pack23[3*gi+2] = enc_a[2*gi+1];
      end
      for (genvar gi = 0; gi < WIDTH/3; gi++) begin : g_p34
         assign pack34[4*gi]   = enc_a[3*gi];
         assign pack34[4*gi+1] = enc_b[3*gi];
         assign pack34[4*gi+2] = enc_a[3*gi+1];
         assign pack34[4*gi+3] = enc_b[3*gi+2];
      end
   endgenerate

   assign pack23[2*WIDTH-1:3*WIDTH/2] = '0;
   assign pack34[2*WIDTH-1:4*WIDTH/3] = '0;

   assign s_axis_tready = !out_valid_q | m_axis_tready;
   assign accept        = s_axis_tvalid & s_axis_tready;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= S_IDLE;
         enc_q       <= '0;
         code_q      <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_user_q  <= '0;
         out_bits_q  <= '0;
      end else begin
         state_q     <= state_d;
         enc_q       <= enc_d;
         code_q      <= code_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         out_user_q  <= out_user_d;
         out_bits_q  <= out_bits_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept && !s_axis_tlast) state_d = S_FRAME;
         S_FRAME: if (accept && s_axis_tlast)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      beat_code   = (state_q == S_IDLE) ? s_axis_tuser : code_q;
      beat_rate   = rate_decode(beat_code);
      code_d      = code_q;
      enc_d       = enc_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      out_user_d  = out_user_q;
      out_bits_d  = out_bits_q;
      if (accept) begin
         if (state_q == S_IDLE) code_d = s_axis_tuser;
         enc_d       = s_axis_tlast ? 6'd0 : st[WIDTH];
         out_valid_d = 1'b1;
         out_last_d  = s_axis_tlast;
         out_user_d  = beat_code;
         case (beat_rate)
            R23:     begin out_data_d = pack23; out_bits_d = BITS23; end
            R34:     begin out_data_d = pack34; out_bits_d = BITS34; end
            default: begin out_data_d = pack12; out_bits_d = BITS12; end
         endcase
      end else if (m_axis_tready) begin
         out_valid_d = 1'b0;
      end
   end

   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tlast  = out_last_q;
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tuser  = out_user_q;
   assign m_axis_tbits  = out_bits_q;

endmodule

// File: tb/tb_ieee80211_conv_punct.sv
// Bench for ieee80211_conv_punct: directed and randomized beats checked against a
// generator-polynomial / puncture-table reference model.
module tb_ieee80211_conv_punct;
   localparam int W  = 24;
   localparam int CW = $clog2(2*W+1);

   logic            aclk;
   logic            areset;
   logic [W-1:0]    s_axis_tdata;
   logic            s_axis_tvalid;
   logic            s_axis_tready;
   logic            s_axis_tlast;
   logic [3:0]      s_axis_tuser;
   logic [2*W-1:0]  m_axis_tdata;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic            m_axis_tlast;
   logic [3:0]      m_axis_tuser;
   logic [CW-1:0]   m_axis_tbits;

   ieee80211_conv_punct #(.WIDTH(W)) dut (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tbits(m_axis_tbits)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [W-1:0] data;
      logic [3:0]   user;
      logic         last;
   } beat_t;

   typedef struct packed {
      logic [2*W-1:0] data;
      logic [CW-1:0]  bits;
      logic           last;
      logic [3:0]     user;
   } out_t;

   beat_t          src [$];
   out_t           expq [$];
   logic [2*W-1:0] popped [$];

   int checks = 0;
   int errors = 0;
   int valid_pct = 100;
   int ready_pct = 100;
   bit s_hold = 0;
   bit stalled_prev = 0;
   out_t snap;

   logic [2*W-1:0] last_data;
   logic [CW-1:0]  last_bits;
   logic           last_last;
   logic [3:0]     last_user;

   // Reference model: shift register as a 6-bit history, MSB = most recent bit
   logic [5:0] m_hist = '0;
   bit         m_in_frame = 0;
   logic [3:0] m_code = '0;
   int period [3] = '{1, 2, 3};
   bit keep_a [3][3] = '{'{1, 1, 1}, '{1, 1, 1}, '{1, 1, 0}};
   bit keep_b [3][3] = '{'{1, 1, 1}, '{1, 0, 1}, '{1, 0, 1}};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int rate_of(input logic [3:0] code);
      case (code)
         4'b0001:                            return 1;
         4'b1111, 4'b0111, 4'b1011, 4'b0011: return 2;
         default:                            return 0;
      endcase
   endfunction

   task automatic model_beat(input beat_t bt);
      logic [3:0] code;
      int         r;
      bit         q [$];
      logic [6:0] w;
      out_t       o;
      code = m_in_frame ? m_code : bt.user;
      if (!m_in_frame) m_code = bt.user;
      r = rate_of(code);
      for (int i = 0; i < W; i++) begin
         w = {bt.data[i], m_hist};
         if (keep_a[r][i % period[r]]) q.push_back(^(w & 7'o133));
         if (keep_b[r][i % period[r]]) q.push_back(^(w & 7'o171));
         m_hist = w[6:1];
      end
      o.data = '0;
      foreach (q[j]) o.data[j] = q[j];
      o.bits = CW'(q.size());
      o.last = bt.last;
      o.user = code;
      if (bt.last) begin
         m_hist = '0;
         m_in_frame = 0;
      end else begin
         m_in_frame = 1;
      end
      expq.push_back(o);
   endtask

   task automatic send(input logic [W-1:0] d, input logic [3:0] u, input logic l);
      beat_t b;
      b.data = d; b.user = u; b.last = l;
      src.push_back(b);
   endtask

   task automatic step_cycle();
      bit   pop, acc;
      out_t e;
      @(negedge aclk);
      if (!s_hold) begin
         if (src.size() > 0 && $urandom_range(99) < valid_pct) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = src[0].data;
            s_axis_tuser  = src[0].user;
            s_axis_tlast  = src[0].last;
         end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = W'($urandom);
            s_axis_tuser  = 4'($urandom);
            s_axis_tlast  = 1'($urandom);
         end
      end
      m_axis_tready = ($urandom_range(99) < ready_pct);
      #1;
      if (stalled_prev) begin
         check("stall_valid", 64'(m_axis_tvalid), 64'd1);
         check("stall_data",  64'(m_axis_tdata), 64'(snap.data));
         check("stall_bits",  64'(m_axis_tbits), 64'(snap.bits));
         check("stall_last",  64'(m_axis_tlast), 64'(snap.last));
         check("stall_user",  64'(m_axis_tuser), 64'(snap.user));
      end
      pop = m_axis_tvalid && m_axis_tready;
      acc = s_axis_tvalid && s_axis_tready;
      if (pop) begin
         if (expq.size() == 0) begin
            check("extra_out_beat", 64'(expq.size()), 64'd1);
         end else begin
            e = expq.pop_front();
            check("out_data", 64'(m_axis_tdata), 64'(e.data));
            check("out_bits", 64'(m_axis_tbits), 64'(e.bits));
            check("out_last", 64'(m_axis_tlast), 64'(e.last));
            check("out_user", 64'(m_axis_tuser), 64'(e.user));
         end
         last_data = m_axis_tdata;
         last_bits = m_axis_tbits;
         last_last = m_axis_tlast;
         last_user = m_axis_tuser;
         popped.push_back(m_axis_tdata);
      end
      if (acc) model_beat(src.pop_front());
      s_hold = s_axis_tvalid && !acc;
      stalled_prev = m_axis_tvalid && !m_axis_tready;
      snap.data = m_axis_tdata;
      snap.bits = m_axis_tbits;
      snap.last = m_axis_tlast;
      snap.user = m_axis_tuser;
   endtask

   task automatic drain();
      int n = 0;
      while ((src.size() > 0 || expq.size() > 0 || m_axis_tvalid) && n < 3000) begin
         step_cycle();
         n++;
      end
      check("drain_pending", 64'(src.size() + expq.size()), 64'd0);
   endtask

   task automatic reset_dut(input int n);
      @(negedge aclk);
      areset = 1'b1;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      s_hold = 0;
      stalled_prev = 0;
      repeat (n) @(posedge aclk);
      m_hist = '0;
      m_in_frame = 0;
      m_code = '0;
      expq.delete();
      src.delete();
      @(negedge aclk);
      areset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2*W-1:0] tmp;
      int n;
      areset = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata = '0;
      s_axis_tuser = '0;
      s_axis_tlast = 1'b0;
      m_axis_tready = 1'b0;

      // Reset state
      reset_dut(3);
      check("rst_valid", 64'(m_axis_tvalid), 64'd0);
      check("rst_data",  64'(m_axis_tdata), 64'd0);
      check("rst_last",  64'(m_axis_tlast), 64'd0);
      check("rst_user",  64'(m_axis_tuser), 64'd0);
      check("rst_bits",  64'(m_axis_tbits), 64'd0);
      check("rst_ready", 64'(s_axis_tready), 64'd1);

      // Single zero beat, rate 1/2
      send('0, 4'b1101, 1'b1);
      drain();
      check("t1_data", 64'(last_data), 64'd0);
      check("t1_bits", 64'(last_bits), 64'd48);
      check("t1_last", 64'(last_last), 64'd1);
      check("t1_user", 64'(last_user), 64'hD);

      // Impulse responses at each rate
      send(24'h000001, 4'b1101, 1'b1);
      drain();
      check("imp12_data", 64'(last_data), 64'h34FB);
      check("imp12_bits", 64'(last_bits), 64'd48);
      send(24'h000001, 4'b1111, 1'b1);
      drain();
      check("imp34_data", 64'(last_data), 64'h33B);
      check("imp34_bits", 64'(last_bits), 64'd32);
      send(24'h000001, 4'b0001, 1'b1);
      drain();
      check("imp23_data", 64'(last_data), 64'h73B);
      check("imp23_bits", 64'(last_bits), 64'd36);

      // State carry across beats, then a fresh frame starts from zero state
      popped.delete();
      send(24'h800000, 4'b1101, 1'b0);
      send(24'h000000, 4'b0001, 1'b1);
      drain();
      check("carry_beats", 64'(popped.size()), 64'd2);
      if (popped.size() >= 2) begin
         tmp = popped[0];
         check("carry_b0_top", 64'(tmp[47:46]), 64'd3);
         tmp = popped[1];
         check("carry_b1_tail", 64'(tmp[11:0]), 64'hD3E);
      end
      check("carry_b1_bits", 64'(last_bits), 64'd48);
      send(24'h000000, 4'b1101, 1'b1);
      drain();
      check("carry_cleared", 64'(last_data), 64'd0);

      // Random 10-beat frame under backpressure with mid-frame tuser changes
      valid_pct = 70;
      ready_pct = 50;
      for (int i = 0; i < 10; i++) send(W'($urandom), 4'($urandom), i == 9);
      drain();
      // A few more random frames, including unknown rate codes and single-beat frames
      for (int f = 0; f < 6; f++) begin
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) send(W'($urandom), 4'($urandom), i == n - 1);
      end
      drain();

      // Reset mid-frame while an output beat is stalled
      valid_pct = 100;
      ready_pct = 0;
      send(W'($urandom), 4'b0001, 1'b0);
      n = 0;
      while (!m_axis_tvalid && n < 20) begin
         step_cycle();
         n++;
      end
      check("t6_pre_valid", 64'(m_axis_tvalid), 64'd1);
      reset_dut(1);
      check("t6_post_valid", 64'(m_axis_tvalid), 64'd0);
      check("t6_post_data",  64'(m_axis_tdata), 64'd0);
      ready_pct = 100;
      send(24'h000001, 4'b1111, 1'b1);
      drain();
      check("t6_data", 64'(last_data), 64'h33B);
      check("t6_bits", 64'(last_bits), 64'd32);
      check("t6_user", 64'(last_user), 64'hF);

      repeat (3) @(negedge aclk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
